// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, in bursts of up to BURST words.
// First write lands one cycle after the request is seen. Every release costs one idle cycle. full stalls the current grant in place.
module fifo_wr_arbiter #(
  parameter int WIDTH = 18,
  parameter int NREQ  = 4,
  parameter int BURST = 8
) (
  input  logic                  wrclk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wr,
  output logic [WIDTH-1:0]      datain,
  input  logic                  full,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [PW-1:0]     gidx;
  logic [PW-1:0]     win_idx;
  logic              win_vld;
  logic              g_valid;
  logic              xfer;

  // Index of the granted requester; grant_q is one-hot or zero.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  // Scan from ptr upward with wrap; walk backwards so the nearest valid index wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign g_valid = req_valid[gidx];
  assign busy    = (state_q == S_GRANT);
  assign grant   = grant_q;
  assign xfer    = busy & g_valid & ~full;
  assign wr      = xfer;

  always_comb begin
    req_ready = '0;
    datain    = '0;
    if (busy) begin
      req_ready = full ? '0 : grant_q;
      datain    = req_data[int'(gidx)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d          = S_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          cnt_d            = '0;
        end
      end
      S_GRANT: begin
        // A requester that drops out releases even under full; otherwise full just holds everything.
        if (!g_valid || (xfer && cnt_q == CW'(BURST - 1))) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = PW'((int'(gidx) + 1) % NREQ);
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester queues, a behavioural FIFO and a grant-order model drive and check the DUT.
module tb_fifo_wr_arbiter;
  localparam int W = 18;
  localparam int N = 4;
  localparam int B = 8;
  typedef logic [W-1:0] word_t;

  logic             wrclk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             wr;
  logic [W-1:0]     datain;
  logic             full;
  logic [N-1:0]     grant;
  logic             busy;

  always #5 wrclk = ~wrclk;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
    .wrclk(wrclk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wr(wr), .datain(datain), .full(full), .grant(grant), .busy(busy)
  );

  word_t rq [N][$];
  word_t fifo_q [$];
  int    wr_seq [N];
  int    rd_seq [N];
  bit    gate [N];
  bit    force_full;
  bit    drain;
  int    fifo_depth;
  int    m_owner, m_ptr, m_words;
  int    n_chk, n_pass, n_wr;
  int    dut_log [$];
  int    burst_log [$];
  int    cur_words;
  logic [N-1:0] prev_grant;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int oh_idx(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic add_words(input int id, input int n);
    logic [1:0]  t;
    logic [15:0] s;
    for (int k = 0; k < n; k++) begin
      t = id[1:0];
      s = wr_seq[id][15:0];
      rq[id].push_back({t, s});
      wr_seq[id]++;
    end
  endtask

  task automatic drive();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = gate[i] && (rq[i].size() > 0);
      if (v[i]) d[i*W +: W] = rq[i][0];
    end
    req_valid = v;
    req_data  = d;
    full      = force_full || (fifo_q.size() >= fifo_depth);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_words = 0;
  endtask

  // One clock: drive just after the edge, check at the falling edge, advance the model at the next edge.
  task automatic cycle();
    logic [N-1:0] e_grant, e_rdy;
    logic         e_wr;
    word_t        e_dat, w;
    int           win;
    drive();
    @(negedge wrclk);
    e_grant = '0; e_rdy = '0; e_wr = 1'b0; e_dat = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_rdy = full ? '0 : e_grant;
      e_wr  = req_valid[m_owner] && !full;
      e_dat = req_data[m_owner*W +: W];
    end
    check_eq("grant", grant, e_grant);
    check_eq("busy", busy, m_owner >= 0);
    check_eq("wr", wr, e_wr);
    check_eq("req_ready", req_ready, e_rdy);
    check_eq("datain", datain, e_dat);
    check_eq("wr_while_full", wr && full, 0);
    if (grant !== prev_grant) begin
      if (prev_grant != 0) burst_log.push_back(cur_words);
      if (grant != 0) dut_log.push_back(oh_idx(grant));
      cur_words  = 0;
      prev_grant = grant;
    end
    if (wr === 1'b1) begin
      fifo_q.push_back(datain);
      n_wr++;
      cur_words++;
    end
    if (e_wr) void'(rq[m_owner].pop_front());
    if (m_owner < 0) begin
      if (|req_valid) begin
        win = -1;
        for (int k = N - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        m_owner = win;
        m_words = 0;
      end
    end else if (!req_valid[m_owner] || (e_wr && m_words == B - 1)) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_words = 0;
    end else if (e_wr) begin
      m_words++;
    end
    if (drain && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      check_eq("rd_order", w[15:0], rd_seq[w[17:16]]);
      rd_seq[w[17:16]]++;
    end
    @(posedge wrclk);
    #1;
  endtask

  task automatic clean_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge wrclk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int base, lb, t;
    bit hit;
    n_chk = 0; n_pass = 0; n_wr = 0; cur_words = 0; prev_grant = '0;
    force_full = 0; drain = 1; fifo_depth = 1 << 20;
    for (int i = 0; i < N; i++) begin gate[i] = 1; wr_seq[i] = 0; rd_seq[i] = 0; end
    model_reset();
    reset_n = 1'b0;
    drive();
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr", wr, 0);
    check_eq("rst_datain", datain, 0);
    @(posedge wrclk); #1;
    reset_n = 1'b1;

    // Single requester, 20 words: bursts of 8, 8, 4.
    base = n_wr; lb = dut_log.size();
    add_words(0, 20);
    repeat (30) cycle();
    check_eq("single_wr_count", n_wr - base, 20);
    check_eq("single_grants", dut_log.size() - lb, 3);
    check_eq("single_drained", rq[0].size(), 0);

    // All four continuously valid: strict rotation, 8 words per grant.
    clean_reset();
    lb = burst_log.size(); t = dut_log.size();
    for (int i = 0; i < N; i++) add_words(i, 24);
    repeat (120) cycle();
    check_eq("rr_grants", dut_log.size() - t, 12);
    for (int k = 0; k < 12 && t + k < dut_log.size(); k++) begin
      check_eq("rr_order", dut_log[t + k], k % N);
      if (lb + k < burst_log.size()) check_eq("rr_burst_len", burst_log[lb + k], B);
    end

    // full held for 5 cycles after the 3rd word of a burst.
    clean_reset();
    base = n_wr; lb = burst_log.size(); hit = 0;
    add_words(1, 8);
    for (int s = 0; s < 40; s++) begin
      cycle();
      if (!hit && n_wr - base == 3) begin
        hit = 1;
        force_full = 1;
        for (int k = 0; k < 5; k++) begin
          cycle();
          check_eq("stall_grant", grant, 4'b0010);
        end
        force_full = 0;
      end
    end
    check_eq("stall_seen", hit, 1);
    check_eq("stall_wr_count", n_wr - base, 8);
    if (burst_log.size() > lb) check_eq("stall_burst_len", burst_log[lb], 8);
    else check_eq("stall_burst_logged", burst_log.size(), lb + 1);

    // Requester 2 drops out after 3 words; requester 3 follows.
    clean_reset();
    t = dut_log.size(); lb = burst_log.size();
    add_words(2, 3);
    add_words(3, 6);
    repeat (20) cycle();
    check_eq("drop_grants", dut_log.size() - t, 2);
    if (dut_log.size() >= t + 2) begin
      check_eq("drop_first", dut_log[t], 2);
      check_eq("drop_next", dut_log[t + 1], 3);
    end
    if (burst_log.size() > lb) check_eq("drop_burst_len", burst_log[lb], 3);

    // Reset mid-burst after word 5.
    clean_reset();
    base = n_wr;
    add_words(0, 10);
    add_words(2, 4);
    for (int s = 0; s < 20 && n_wr - base < 5; s++) cycle();
    check_eq("mid_pre_words", n_wr - base, 5);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_wr", wr, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_grant", grant, 0);
    check_eq("mid_rst_ready", req_ready, 0);
    model_reset();
    @(posedge wrclk); #1;
    check_eq("mid_rst_hold_wr", wr, 0);
    reset_n = 1'b1;
    t = dut_log.size();
    repeat (30) cycle();
    if (dut_log.size() > t) check_eq("mid_restart_grant", dut_log[t], 0);
    else check_eq("mid_restart_seen", dut_log.size(), t + 1);
    check_eq("mid_total_words", n_wr - base, 14);

    // Random traffic with random full; requesters hold still while full is forced.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 5) == 0) force_full = 1;
      else if (force_full && $urandom_range(0, 1) == 0) force_full = 0;
      if (!force_full) for (int i = 0; i < N; i++) gate[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) add_words(i, 1);
      cycle();
    end
    force_full = 0;
    for (int i = 0; i < N; i++) gate[i] = 1;
    for (int s = 0; s < 400 && (m_owner >= 0 || fifo_q.size() > 0 ||
         rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() > 0); s++) cycle();
    check_eq("rand_flush", fifo_q.size() + rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size(), 0);

    // End to end: fill a 16-deep FIFO until full, then drain until empty.
    clean_reset();
    fifo_depth = 16; drain = 0; hit = 0;
    add_words(0, 20);
    add_words(1, 20);
    for (int s = 0; s < 100 && !hit; s++) begin
      cycle();
      hit = (fifo_q.size() >= fifo_depth);
    end
    check_eq("e2e_filled", hit, 1);
    repeat (3) cycle();
    check_eq("e2e_no_overfill", fifo_q.size(), 16);
    drain = 1;
    for (int s = 0; s < 400 && (fifo_q.size() > 0 || rq[0].size() + rq[1].size() > 0); s++) cycle();
    check_eq("e2e_empty", fifo_q.size(), 0);
    for (int i = 0; i < N; i++) check_eq("all_read_back", rd_seq[i], wr_seq[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
